// File: rtl/polygon_draw_scheduler.sv
// Round-robin scheduler sharing one polygon draw engine among several sources.
// Optional BUSY watchdog enabled by defining DRAW_TIMEOUT_EN.
module polygon_draw_scheduler #(
    parameter int unsigned NUM_REQUESTERS   = 4,
    parameter int unsigned MAX_NUM_VERTICES = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 1048576
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [NUM_REQUESTERS-1:0]           req_in,
    input  logic signed [31:0]                  xs_in [NUM_REQUESTERS][MAX_NUM_VERTICES],
    input  logic signed [31:0]                  ys_in [NUM_REQUESTERS][MAX_NUM_VERTICES],
    input  logic [$clog2(MAX_NUM_VERTICES):0]   num_points_in [NUM_REQUESTERS],
    input  logic                                pause_in,
    input  logic                                draw_done_in,
    output logic [NUM_REQUESTERS-1:0]           grant_out,
    output logic                                draw_start_out,
    output logic signed [31:0]                  xs_out [MAX_NUM_VERTICES],
    output logic signed [31:0]                  ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES):0]   num_points_out,
    output logic                                busy_out,
    output logic                                reject_out,
    output logic [15:0]                         draw_count_out,
    output logic                                timeout_out
);
    localparam int unsigned IdxW = $clog2(NUM_REQUESTERS);
    localparam int unsigned NpW  = $clog2(MAX_NUM_VERTICES) + 1;

    if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("polygon_draw_scheduler: illegal parameter value");
    end

    typedef enum logic [1:0] {StIdle, StLoad, StStart, StBusy} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        winner_q, winner_d;
    logic [IdxW-1:0]        last_winner_q, last_winner_d;
    logic signed [31:0]     xs_q [MAX_NUM_VERTICES];
    logic signed [31:0]     xs_d [MAX_NUM_VERTICES];
    logic signed [31:0]     ys_q [MAX_NUM_VERTICES];
    logic signed [31:0]     ys_d [MAX_NUM_VERTICES];
    logic [NpW-1:0]         num_points_q, num_points_d;
    logic [15:0]            draw_count_q, draw_count_d;

    logic [IdxW-1:0]        pick_idx;
    logic [IdxW-1:0]        cand;
    logic                   pick_found;
    logic                   pts_valid;

`ifdef DRAW_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                   timeout_q, timeout_d;
`endif

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        pick_idx   = last_winner_q;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 1; i <= int'(NUM_REQUESTERS); i++) begin
            cand = IdxW'((int'(last_winner_q) + i) % int'(NUM_REQUESTERS));
            if (!pick_found && req_in[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign pts_valid = (num_points_in[winner_q] >= NpW'(3)) &&
                       (num_points_in[winner_q] <= NpW'(MAX_NUM_VERTICES));

    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        last_winner_d  = last_winner_q;
        xs_d           = xs_q;
        ys_d           = ys_q;
        num_points_d   = num_points_q;
        draw_count_d   = draw_count_q;
        grant_out      = '0;
        draw_start_out = 1'b0;
        reject_out     = 1'b0;
`ifdef DRAW_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        timeout_d      = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!pause_in && pick_found) begin
                    winner_d = pick_idx;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                grant_out[winner_q] = 1'b1;
                last_winner_d       = winner_q;
                if (pts_valid) begin
                    xs_d         = xs_in[winner_q];
                    ys_d         = ys_in[winner_q];
                    num_points_d = num_points_in[winner_q];
                    state_d      = StStart;
                end else begin
                    reject_out = 1'b1;
                    state_d    = StIdle;
                end
            end
            StStart: begin
                draw_start_out = 1'b1;
                state_d        = StBusy;
`ifdef DRAW_TIMEOUT_EN
                tmo_cnt_d      = '0;
`endif
            end
            StBusy: begin
                if (draw_done_in) begin
                    draw_count_d = draw_count_q + 16'd1;
                    state_d      = StIdle;
                end
`ifdef DRAW_TIMEOUT_EN
                else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= StIdle;
            winner_q      <= '0;
            last_winner_q <= IdxW'(NUM_REQUESTERS - 1);
            for (int v = 0; v < int'(MAX_NUM_VERTICES); v++) begin
                xs_q[v] <= '0;
                ys_q[v] <= '0;
            end
            num_points_q  <= '0;
            draw_count_q  <= '0;
`ifdef DRAW_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            last_winner_q <= last_winner_d;
            xs_q          <= xs_d;
            ys_q          <= ys_d;
            num_points_q  <= num_points_d;
            draw_count_q  <= draw_count_d;
`ifdef DRAW_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign busy_out       = (state_q != StIdle);
    assign xs_out         = xs_q;
    assign ys_out         = ys_q;
    assign num_points_out = num_points_q;
    assign draw_count_out = draw_count_q;
`ifdef DRAW_TIMEOUT_EN
    assign timeout_out    = timeout_q;
`else
    assign timeout_out    = 1'b0;
`endif

endmodule

// File: tb/tb_polygon_draw_scheduler.sv
// Directed self-checking bench for polygon_draw_scheduler (4 sources, 4 vertices).
module tb_polygon_draw_scheduler;
    logic               clk_in;
    logic               rst_in;
    logic [3:0]         req_in;
    logic signed [31:0] xs_in [4][4];
    logic signed [31:0] ys_in [4][4];
    logic [2:0]         num_points_in [4];
    logic               pause_in;
    logic               draw_done_in;
    logic [3:0]         grant_out;
    logic               draw_start_out;
    logic signed [31:0] xs_out [4];
    logic signed [31:0] ys_out [4];
    logic [2:0]         num_points_out;
    logic               busy_out;
    logic               reject_out;
    logic [15:0]        draw_count_out;
    logic               timeout_out;

    int checks = 0;
    int failures = 0;

    polygon_draw_scheduler #(
        .NUM_REQUESTERS  (4),
        .MAX_NUM_VERTICES(4),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_in        (req_in),
        .xs_in         (xs_in),
        .ys_in         (ys_in),
        .num_points_in (num_points_in),
        .pause_in      (pause_in),
        .draw_done_in  (draw_done_in),
        .grant_out     (grant_out),
        .draw_start_out(draw_start_out),
        .xs_out        (xs_out),
        .ys_out        (ys_out),
        .num_points_out(num_points_out),
        .busy_out      (busy_out),
        .reject_out    (reject_out),
        .draw_count_out(draw_count_out),
        .timeout_out   (timeout_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        rst_in       = 1'b1;
        req_in       = '0;
        pause_in     = 1'b0;
        draw_done_in = 1'b0;
        for (int r = 0; r < 4; r++) begin
            num_points_in[r] = 3'd4;
            for (int v = 0; v < 4; v++) begin
                xs_in[r][v] = 32'(r * 100 + v * 10 + 1);
                ys_in[r][v] = 32'(r * 100 + v * 10 + 2);
            end
        end
        step();
        step();
        rst_in = 1'b0;
        step();
        chk("rst_grant", 64'(grant_out), 64'h0);
        chk("rst_start", 64'(draw_start_out), 64'h0);
        chk("rst_busy", 64'(busy_out), 64'h0);
        chk("rst_reject", 64'(reject_out), 64'h0);
        chk("rst_count", 64'(draw_count_out), 64'h0);
        chk("rst_xs0", 64'(xs_out[0]), 64'h0);
        chk("rst_np", 64'(num_points_out), 64'h0);
        chk("rst_timeout", 64'(timeout_out), 64'h0);

        // Single request from source 2.
        req_in = 4'b0100;
        step();
        chk("single_grant", 64'(grant_out), 64'h4);
        chk("single_busy", 64'(busy_out), 64'h1);
        chk("single_nostart", 64'(draw_start_out), 64'h0);
        req_in = 4'b0000;
        step();
        chk("single_start", 64'(draw_start_out), 64'h1);
        chk("single_grant_off", 64'(grant_out), 64'h0);
        chk("single_xs0", 64'(xs_out[0]), 64'd201);
        chk("single_xs3", 64'(xs_out[3]), 64'd231);
        chk("single_ys1", 64'(ys_out[1]), 64'd212);
        chk("single_np", 64'(num_points_out), 64'd4);
        draw_done_in = 1'b1;  // coincident with start: must be ignored
        step();
        draw_done_in = 1'b0;
        chk("early_done_busy", 64'(busy_out), 64'h1);
        chk("early_done_count", 64'(draw_count_out), 64'd0);
        chk("busy_start_off", 64'(draw_start_out), 64'h0);
        step();
        step();
        chk("busy_wait", 64'(busy_out), 64'h1);
        draw_done_in = 1'b1;
        step();
        draw_done_in = 1'b0;
        chk("done_busy", 64'(busy_out), 64'h0);
        chk("done_count", 64'(draw_count_out), 64'd1);

        // Pause raised during BUSY; last winner is 2 so source 3 goes first.
        req_in = 4'b1111;
        step();
        chk("pause_first_grant", 64'(grant_out), 64'h8);
        step();
        step();
        pause_in = 1'b1;
        step();
        step();
        draw_done_in = 1'b1;
        step();
        draw_done_in = 1'b0;
        chk("pause_done_busy", 64'(busy_out), 64'h0);
        chk("pause_done_count", 64'(draw_count_out), 64'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("paused_nogrant", 64'(grant_out), 64'h0);
            chk("paused_idle", 64'(busy_out), 64'h0);
        end
        pause_in = 1'b0;
        step();
        chk("unpause_grant", 64'(grant_out), 64'h1);
        step();
        chk("unpause_start", 64'(draw_start_out), 64'h1);
        step();
        chk("unpause_busy", 64'(busy_out), 64'h1);

        // Reset while BUSY, then a late done.
        req_in = 4'b0000;
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("bsyrst_grant", 64'(grant_out), 64'h0);
        chk("bsyrst_start", 64'(draw_start_out), 64'h0);
        chk("bsyrst_busy", 64'(busy_out), 64'h0);
        chk("bsyrst_count", 64'(draw_count_out), 64'd0);
        chk("bsyrst_xs0", 64'(xs_out[0]), 64'h0);
        chk("bsyrst_np", 64'(num_points_out), 64'h0);
        draw_done_in = 1'b1;
        step();
        draw_done_in = 1'b0;
        chk("late_done_count", 64'(draw_count_out), 64'd0);
        chk("late_done_busy", 64'(busy_out), 64'h0);

        // All sources requesting continuously: grants 0,1,2,3,0,1.
        req_in = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            exp_g = 4'b0001 << (k % 4);
            step();
            chk("rr_grant", 64'(grant_out), 64'(exp_g));
            step();
            chk("rr_start", 64'(draw_start_out), 64'h1);
            chk("rr_start_nogrant", 64'(grant_out), 64'h0);
            for (int j = 0; j < 9; j++) begin
                step();
                chk("rr_busy_nogrant", 64'(grant_out), 64'h0);
            end
            draw_done_in = 1'b1;
            step();
            draw_done_in = 1'b0;
            chk("rr_idle", 64'(busy_out), 64'h0);
            chk("rr_count", 64'(draw_count_out), 64'(k + 1));
        end
        req_in = 4'b0000;

        // Illegal vertex counts on source 1 (2, then 5).
        xs_in[1][0] = 32'd999;
        num_points_in[1] = 3'd2;
        req_in = 4'b0010;
        step();
        chk("rej2_grant", 64'(grant_out), 64'h2);
        chk("rej2_reject", 64'(reject_out), 64'h1);
        req_in = 4'b0000;
        step();
        chk("rej2_nostart", 64'(draw_start_out), 64'h0);
        chk("rej2_reject_off", 64'(reject_out), 64'h0);
        chk("rej2_idle", 64'(busy_out), 64'h0);
        chk("rej2_xs0", 64'(xs_out[0]), 64'd101);
        chk("rej2_np", 64'(num_points_out), 64'd4);
        chk("rej2_count", 64'(draw_count_out), 64'd6);
        num_points_in[1] = 3'd5;
        req_in = 4'b0010;
        step();
        chk("rej5_grant", 64'(grant_out), 64'h2);
        chk("rej5_reject", 64'(reject_out), 64'h1);
        req_in = 4'b0000;
        step();
        chk("rej5_nostart", 64'(draw_start_out), 64'h0);
        chk("rej5_xs0", 64'(xs_out[0]), 64'd101);
        chk("rej5_count", 64'(draw_count_out), 64'd6);
        num_points_in[1] = 3'd4;
        xs_in[1][0] = 32'd101;

`ifdef DRAW_TIMEOUT_EN
        // Engine never signals done: abort after 16 BUSY cycles.
        req_in = 4'b0001;
        step();
        chk("tmo_grant", 64'(grant_out), 64'h1);
        req_in = 4'b0000;
        step();
        step();
        for (int i = 0; i < 15; i++) step();
        chk("tmo_still_busy", 64'(busy_out), 64'h1);
        chk("tmo_not_yet", 64'(timeout_out), 64'h0);
        step();
        chk("tmo_abort_idle", 64'(busy_out), 64'h0);
        chk("tmo_flag", 64'(timeout_out), 64'h1);
        chk("tmo_count", 64'(draw_count_out), 64'd6);
        req_in = 4'b0010;
        step();
        chk("tmo_next_grant", 64'(grant_out), 64'h2);
        req_in = 4'b0000;
        step();
        chk("tmo_sticky", 64'(timeout_out), 64'h1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("tmo_rst", 64'(timeout_out), 64'h0);
`else
        chk("no_timeout", 64'(timeout_out), 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
